parking_meter_timer: RTL

- Upstream of the 7-segment flasher/display path: holds the parking-meter time remaining as a 4-digit packed BCD value (0000–9999 seconds).
- Applies coin-add and preset requests from debounced pushbuttons.
- Counts down once per second from an internal prescaler.
- Drives the BCD word consumed by the flasher and the digit muxing.

---
 rtl/parking_meter_pkg.sv | 24 ++
 rtl/bcd4_add_sat.sv | 32 +++
 rtl/parking_meter_timer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/parking_meter_pkg.sv
// rtl/parking_meter_pkg.sv - shared BCD constants and request encoding for the parking meter
package parking_meter_pkg;

  localparam logic [15:0] BCD_ADD_10      = 16'h0010;
  localparam logic [15:0] BCD_ADD_180     = 16'h0180;
  localparam logic [15:0] BCD_ADD_200     = 16'h0200;
  localparam logic [15:0] BCD_ADD_550     = 16'h0550;
  localparam logic [15:0] BCD_PRESET_15   = 16'h0015;
  localparam logic [15:0] BCD_PRESET_150  = 16'h0150;
  localparam logic [15:0] BCD_MAX         = 16'h9999;
  // Blink threshold shared with the flasher so both blocks agree on it.
  localparam logic [15:0] BCD_FLASH_THRESH = 16'h0180;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_PRESET_150,
    REQ_PRESET_15,
    REQ_ADD_550,
    REQ_ADD_200,
    REQ_ADD_180,
    REQ_ADD_10
  } req_e;

endpackage

// File: rtl/bcd4_add_sat.sv
// rtl/bcd4_add_sat.sv - combinational 4-digit packed-BCD adder saturating at 9999
module bcd4_add_sat
  import parking_meter_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic [4:0]  w_digit;
  logic        w_carry;
  logic [15:0] w_raw;

  always_comb begin
    w_digit = '0;
    w_carry = 1'b0;
    w_raw   = '0;
    for (int i = 0; i < 4; i++) begin
      w_digit = {1'b0, i_a[i*4 +: 4]} + {1'b0, i_b[i*4 +: 4]} + {4'b0, w_carry};
      // Adding 6 and keeping the low nibble is the same as subtracting 10.
      if (w_digit > 5'd9) begin
        w_digit = w_digit + 5'd6;
        w_carry = 1'b1;
      end else begin
        w_carry = 1'b0;
      end
      w_raw[i*4 +: 4] = w_digit[3:0];
    end
    o_sum = w_carry ? BCD_MAX : w_raw;
  end

endmodule

// File: rtl/parking_meter_timer.sv
// rtl/parking_meter_timer.sv - BCD time-remaining counter with button adds/presets and 1 Hz countdown
// Optional PARKING_HALF_HZ_EN adds the clk_half_hz blink output.
module parking_meter_timer
  import parking_meter_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_10,
  input  logic        add_180,
  input  logic        add_200,
  input  logic        add_550,
  input  logic        preset_15,
  input  logic        preset_150,
  output logic [15:0] bcd_out,
  output logic        tick_1hz
`ifdef PARKING_HALF_HZ_EN
  ,
  output logic        clk_half_hz
`endif
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] r_prescale;
  logic [5:0]    r_btn;
  logic [5:0]    r_btn_d;
  logic [15:0]   r_bcd;

  logic [5:0]    w_btn;
  logic [5:0]    w_rise;
  req_e          w_req;
  logic [15:0]   w_base;
  logic [15:0]   w_add_k;
  logic [15:0]   w_sum;
  logic [15:0]   w_next;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_btn    = {preset_150, preset_15, add_550, add_200, add_180, add_10};
  assign w_rise   = r_btn & ~r_btn_d;
  assign tick_1hz = (r_prescale == PW'(CLK_HZ - 1));
  assign bcd_out  = r_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_btn      <= '0;
      r_btn_d    <= '0;
      r_bcd      <= '0;
    end else begin
      r_prescale <= tick_1hz ? '0 : r_prescale + 1'b1;
      r_btn      <= w_btn;
      r_btn_d    <= r_btn;
      r_bcd      <= w_next;
    end
  end

  // Only the highest-priority edge is honoured; the rest are dropped.
  always_comb begin
    w_req = REQ_NONE;
    if      (w_rise[5]) w_req = REQ_PRESET_150;
    else if (w_rise[4]) w_req = REQ_PRESET_15;
    else if (w_rise[3]) w_req = REQ_ADD_550;
    else if (w_rise[2]) w_req = REQ_ADD_200;
    else if (w_rise[1]) w_req = REQ_ADD_180;
    else if (w_rise[0]) w_req = REQ_ADD_10;
  end

  always_comb begin
    w_add_k = BCD_ADD_10;
    case (w_req)
      REQ_ADD_550: w_add_k = BCD_ADD_550;
      REQ_ADD_200: w_add_k = BCD_ADD_200;
      REQ_ADD_180: w_add_k = BCD_ADD_180;
      default:     w_add_k = BCD_ADD_10;
    endcase
  end

  assign w_base = (tick_1hz && (r_bcd != 16'h0000)) ? bcd_dec(r_bcd) : r_bcd;

  bcd4_add_sat u_add (
    .i_a   (w_base),
    .i_b   (w_add_k),
    .o_sum (w_sum)
  );

  always_comb begin
    w_next = w_base;
    case (w_req)
      REQ_PRESET_150: w_next = BCD_PRESET_150;
      REQ_PRESET_15:  w_next = BCD_PRESET_15;
      REQ_ADD_550,
      REQ_ADD_200,
      REQ_ADD_180,
      REQ_ADD_10:     w_next = w_sum;
      default:        w_next = w_base;
    endcase
  end

`ifdef PARKING_HALF_HZ_EN
  logic r_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_half <= 1'b0;
    else if (tick_1hz) r_half <= ~r_half;
  end

  assign clk_half_hz = r_half;
`endif

endmodule
